// File: rtl/ccff_chain_loader.sv
// Streams host words LSB-first into a configuration flip-flop chain and
// reassembles the bits that fall off the chain tail into readback words.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 10,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clock,
   input  logic              prog_reset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              config_enable,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   output logic              busy,
   output logic              done
);

   localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
   localparam int CW        = $clog2(WORD_W + 1);
   localparam int NWW       = $clog2(NWORDS + 1);
   localparam int SW        = $clog2(CHAIN_LEN + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NWW-1:0]    owed_q, owed_d;
   logic [SW-1:0]     shifted_q, shifted_d;
   logic [WORD_W-1:0] rb_acc_q, rb_acc_d;
   logic [CW-1:0]     rb_cnt_q, rb_cnt_d;
   logic [WORD_W-1:0] rb_data_q, rb_data_d;
   logic              rb_valid_q, rb_valid_d;
   logic              en_q, en_d;
   logic              head_q, head_d;

   logic              hs;
   logic              last_shift;
   logic [CW-1:0]     load_bits;
   logic [WORD_W-1:0] load_mask;
   logic [WORD_W-1:0] rb_acc_nxt;

   // A word may land while the final buffered bit is leaving, so loading never bubbles.
   assign cfg_ready  = (state_q == SHIFT) && (owed_q != '0) &&
                       ((cnt_q == '0) || ((cnt_q == CW'(1)) && en_q));
   assign hs         = cfg_valid && cfg_ready;
   assign last_shift = (shifted_q == SW'(CHAIN_LEN - 1));
   assign load_bits  = (owed_q == NWW'(1)) ? CW'(LAST_BITS) : CW'(WORD_W);

   always_comb begin
      load_mask = '0;
      for (int i = 0; i < WORD_W; i++) begin
         load_mask[i] = (i < int'(load_bits));
      end
   end

   always_comb begin
      rb_acc_nxt = rb_acc_q;
      for (int i = 0; i < WORD_W; i++) begin
         if (rb_cnt_q == CW'(i)) rb_acc_nxt[i] = ccff_tail;
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      owed_d     = owed_q;
      shifted_d  = shifted_q;
      rb_acc_d   = rb_acc_q;
      rb_cnt_d   = rb_cnt_q;
      rb_data_d  = rb_data_q;
      rb_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SHIFT;
               shreg_d   = '0;
               cnt_d     = '0;
               owed_d    = NWW'(NWORDS);
               shifted_d = '0;
               rb_acc_d  = '0;
               rb_cnt_d  = '0;
            end
         end
         SHIFT: begin
            if (en_q) begin
               shreg_d   = shreg_q >> 1;
               cnt_d     = cnt_q - CW'(1);
               shifted_d = shifted_q + SW'(1);
               // Flush a readback word when full or when the chain's last bit arrives.
               if ((rb_cnt_q == CW'(WORD_W - 1)) || last_shift) begin
                  rb_data_d  = rb_acc_nxt;
                  rb_valid_d = 1'b1;
                  rb_acc_d   = '0;
                  rb_cnt_d   = '0;
               end else begin
                  rb_acc_d = rb_acc_nxt;
                  rb_cnt_d = rb_cnt_q + CW'(1);
               end
               if (last_shift) state_d = DONE;
            end
            if (hs) begin
               shreg_d = cfg_data & load_mask;
               cnt_d   = load_bits;
               owed_d  = owed_q - NWW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      en_d   = (state_d == SHIFT) && (cnt_d != '0);
      head_d = shreg_d[0];
   end

   always_ff @(posedge prog_clock) begin
      if (prog_reset) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         cnt_q      <= '0;
         owed_q     <= '0;
         shifted_q  <= '0;
         rb_acc_q   <= '0;
         rb_cnt_q   <= '0;
         rb_data_q  <= '0;
         rb_valid_q <= 1'b0;
         en_q       <= 1'b0;
         head_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         owed_q     <= owed_d;
         shifted_q  <= shifted_d;
         rb_acc_q   <= rb_acc_d;
         rb_cnt_q   <= rb_cnt_d;
         rb_data_q  <= rb_data_d;
         rb_valid_q <= rb_valid_d;
         en_q       <= en_d;
         head_q     <= head_d;
      end
   end

   assign config_enable = en_q;
   assign ccff_head     = head_q;
   assign rb_data       = rb_data_q;
   assign rb_valid      = rb_valid_q;
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader driving a 10-FF behavioural chain; expected
// values come from a FIFO-of-bits model of the chain contents.
module tb_ccff_chain_loader;

   localparam int CL = 10;
   localparam int WW = 8;
   localparam int NW = 2;

   logic          prog_clock = 1'b0;
   logic          prog_reset, start, cfg_valid, ccff_tail;
   logic [WW-1:0] cfg_data, rb_data;
   logic          cfg_ready, config_enable, ccff_head, rb_valid, busy, done;
   logic [CL-1:0] chain = '1;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int            en_cnt = 0, bubbles = 0, hs_cyc = -1, first_en_cyc = -1;
   int            last_en_cyc = -1, done_cyc = -1, done_cnt = 0, last_rb_cyc = -1;
   logic [CL-1:0] obs_heads = '0;
   logic [WW-1:0] obs_rb[$];
   bit            mq[$];

   ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
      .prog_clock   (prog_clock),
      .prog_reset   (prog_reset),
      .start        (start),
      .cfg_data     (cfg_data),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .config_enable(config_enable),
      .ccff_head    (ccff_head),
      .ccff_tail    (ccff_tail),
      .rb_data      (rb_data),
      .rb_valid     (rb_valid),
      .busy         (busy),
      .done         (done)
   );

   always #5 prog_clock = ~prog_clock;
   always @(posedge prog_clock) cyc <= cyc + 1;

   // behavioural chain: head enters bit 0, tail is the last flip-flop
   always @(posedge prog_clock) if (config_enable) chain <= {chain[CL-2:0], ccff_head};
   assign ccff_tail = chain[CL-1];

   // observation side, restarted whenever a pass is launched from IDLE
   always @(negedge prog_clock) begin
      if (start && !busy && !prog_reset) begin
         en_cnt = 0; bubbles = 0; hs_cyc = -1; first_en_cyc = -1; last_en_cyc = -1;
         done_cyc = -1; done_cnt = 0; last_rb_cyc = -1; obs_heads = '0; obs_rb.delete();
      end else begin
         if (cfg_valid && cfg_ready && hs_cyc < 0) hs_cyc = cyc;
         if (config_enable) begin
            if (en_cnt < CL) obs_heads[en_cnt] = ccff_head;
            en_cnt++;
            if (first_en_cyc < 0) first_en_cyc = cyc;
            last_en_cyc = cyc;
         end else if (busy && !done && en_cnt > 0 && en_cnt < CL) begin
            bubbles++;
         end
         if (rb_valid) begin obs_rb.push_back(rb_data); last_rb_cyc = cyc; end
         if (done) begin done_cnt++; done_cyc = cyc; end
      end
   end

   function automatic logic [CL-1:0] heads_of(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
      logic [WW-1:0] w [NW];
      logic [CL-1:0] r;
      w[0] = w0; w[1] = w1;
      for (int i = 0; i < CL; i++) r[i] = w[i/WW][i%WW];
      return r;
   endfunction

   // a full pass pushes CL new bits in and pops the CL old bits out
   task automatic model_pass(input logic [CL-1:0] heads, output logic [WW-1:0] e0, output logic [WW-1:0] e1);
      logic [WW-1:0] e [NW];
      e[0] = '0; e[1] = '0;
      for (int i = 0; i < CL; i++) begin
         e[i/WW][i%WW] = mq.pop_front();
         mq.push_back(heads[i]);
      end
      e0 = e[0]; e1 = e[1];
   endtask

   task automatic send_word(input logic [WW-1:0] w, output bit tmo);
      int n = 0;
      cfg_data = w; cfg_valid = 1'b1;
      while (!cfg_ready && n < 40) begin @(posedge prog_clock); #1; n++; end
      tmo = !cfg_ready;
      @(posedge prog_clock); #1;
   endtask

   task automatic do_pass(input logic [WW-1:0] w0, input logic [WW-1:0] w1, input int gap,
                          input bit noisy, output bit tmo);
      bit t0, t1;
      int n = 0;
      start = 1'b1; @(posedge prog_clock); #1; start = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge prog_clock); #1; end
      send_word(w0, t0);
      if (gap > 0) begin
         cfg_valid = 1'b0;
         start = noisy;
         repeat (WW - 1 + gap) begin @(posedge prog_clock); #1; end
         start = 1'b0;
      end
      send_word(w1, t1);
      cfg_valid = 1'b0;
      while (!done && n < 60) begin @(posedge prog_clock); #1; n++; end
      tmo = t0 | t1 | !done;
      @(posedge prog_clock); #1;
   endtask

   task automatic test_reset;
      prog_reset = 1'b1; start = 1'b1; cfg_valid = 1'b0; cfg_data = '0;
      repeat (2) begin @(posedge prog_clock); #1; end
      checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL reset_cfg_ready got=%b want=0", cfg_ready); end
      checks++; if (config_enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b want=0", config_enable); end
      checks++; if (ccff_head !== 1'b0) begin failures++; $display("FAIL reset_head got=%b want=0", ccff_head); end
      checks++; if (rb_valid !== 1'b0) begin failures++; $display("FAIL reset_rb_valid got=%b want=0", rb_valid); end
      checks++; if (rb_data !== '0) begin failures++; $display("FAIL reset_rb_data got=%h want=00", rb_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      start = 1'b0; prog_reset = 1'b0;
      @(posedge prog_clock); #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_after got=%b want=0", busy); end
   endtask

   task automatic test_load;
      logic [WW-1:0] e0, e1;
      bit tmo;
      model_pass(heads_of(8'hA5, 8'h03), e0, e1);
      do_pass(8'hA5, 8'h03, 0, 1'b0, tmo);
      checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL load_timeout got=%b want=0", tmo); end
      checks++; if (obs_heads !== 10'h3A5) begin failures++; $display("FAIL load_heads got=%h want=3a5", obs_heads); end
      checks++; if (en_cnt !== CL) begin failures++; $display("FAIL load_shifts got=%0d want=%0d", en_cnt, CL); end
      checks++; if (last_en_cyc - first_en_cyc !== CL - 1) begin failures++; $display("FAIL load_consecutive got=%0d want=%0d", last_en_cyc - first_en_cyc, CL - 1); end
      checks++; if (first_en_cyc - hs_cyc !== 1) begin failures++; $display("FAIL load_first_shift got=%0d want=1", first_en_cyc - hs_cyc); end
      checks++; if (done_cnt !== 1 || done_cyc !== last_en_cyc + 1) begin failures++; $display("FAIL load_done got=%0d@%0d want=1@%0d", done_cnt, done_cyc, last_en_cyc + 1); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL load_busy_fall got=%b%b want=00", busy, done); end
      checks++; if (obs_rb.size() !== 2) begin failures++; $display("FAIL load_rb_count got=%0d want=2", obs_rb.size()); end
      checks++; if (obs_rb[0] !== 8'hFF || obs_rb[1] !== 8'h03) begin failures++; $display("FAIL load_readback got=%h,%h want=ff,03", obs_rb[0], obs_rb[1]); end
      checks++; if (e0 !== 8'hFF || e1 !== 8'h03) begin failures++; $display("FAIL load_model_rb got=%h,%h want=ff,03", e0, e1); end
      checks++; if (last_rb_cyc !== done_cyc) begin failures++; $display("FAIL load_last_rb_cycle got=%0d want=%0d", last_rb_cyc, done_cyc); end
   endtask

   task automatic test_readback;
      logic [WW-1:0] e0, e1;
      bit tmo;
      model_pass(heads_of(8'h00, 8'h00), e0, e1);
      do_pass(8'h00, 8'h00, 0, 1'b0, tmo);
      checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL rb_timeout got=%b want=0", tmo); end
      checks++; if (obs_rb.size() !== 2) begin failures++; $display("FAIL rb_count got=%0d want=2", obs_rb.size()); end
      checks++; if (obs_rb[0] !== 8'hA5 || obs_rb[1] !== 8'h03) begin failures++; $display("FAIL rb_data got=%h,%h want=a5,03", obs_rb[0], obs_rb[1]); end
      checks++; if (obs_heads !== '0) begin failures++; $display("FAIL rb_heads got=%h want=000", obs_heads); end
      checks++; if (rb_data !== 8'h03) begin failures++; $display("FAIL rb_hold got=%h want=03", rb_data); end
   endtask

   task automatic test_underrun;
      logic [WW-1:0] e0, e1;
      bit tmo;
      model_pass(heads_of(8'hA5, 8'h03), e0, e1);
      do_pass(8'hA5, 8'h03, 3, 1'b0, tmo);
      checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL under_timeout got=%b want=0", tmo); end
      checks++; if (bubbles !== 3) begin failures++; $display("FAIL under_bubbles got=%0d want=3", bubbles); end
      checks++; if (obs_heads !== 10'h3A5) begin failures++; $display("FAIL under_heads got=%h want=3a5", obs_heads); end
      checks++; if (en_cnt !== CL) begin failures++; $display("FAIL under_shifts got=%0d want=%0d", en_cnt, CL); end
      checks++; if (obs_rb.size() !== 2 || obs_rb[0] !== e0 || obs_rb[1] !== e1) begin failures++; $display("FAIL under_readback got=%h,%h want=%h,%h", obs_rb[0], obs_rb[1], e0, e1); end
   endtask

   task automatic test_start_ignored;
      logic [WW-1:0] w0, w1, e0, e1;
      logic [CL-1:0] eh;
      bit tmo;
      w0 = 8'($urandom); w1 = 8'($urandom);
      eh = heads_of(w0, w1);
      model_pass(eh, e0, e1);
      do_pass(w0, w1, 2, 1'b1, tmo);
      checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL start_ign_timeout got=%b want=0", tmo); end
      checks++; if (en_cnt !== CL || done_cnt !== 1) begin failures++; $display("FAIL start_ign_pass got=%0d/%0d want=%0d/1", en_cnt, done_cnt, CL); end
      checks++; if (obs_heads !== eh) begin failures++; $display("FAIL start_ign_heads got=%h want=%h", obs_heads, eh); end
      checks++; if (obs_rb.size() !== 2 || obs_rb[0] !== e0 || obs_rb[1] !== e1) begin failures++; $display("FAIL start_ign_readback got=%h,%h want=%h,%h", obs_rb[0], obs_rb[1], e0, e1); end
   endtask

   task automatic test_abort;
      logic [WW-1:0] w0;
      bit tmo;
      int n = 0;
      w0 = 8'($urandom);
      start = 1'b1; @(posedge prog_clock); #1; start = 1'b0;
      send_word(w0, tmo);
      cfg_valid = 1'b0;
      while (en_cnt < 5 && n < 40) begin @(negedge prog_clock); #1; n++; end
      checks++; if (en_cnt !== 5) begin failures++; $display("FAIL abort_reach5 got=%0d want=5", en_cnt); end
      prog_reset = 1'b1;
      @(posedge prog_clock); #1;
      checks++; if (config_enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_stop got=%b%b want=00", config_enable, busy); end
      prog_reset = 1'b0;
      repeat (5) begin @(posedge prog_clock); #1; end
      checks++; if (en_cnt !== 5) begin failures++; $display("FAIL abort_no_more_shifts got=%0d want=5", en_cnt); end
      checks++; if (done_cnt !== 0 || obs_rb.size() !== 0) begin failures++; $display("FAIL abort_no_done_rb got=%0d/%0d want=0/0", done_cnt, obs_rb.size()); end
      for (int i = 0; i < 5; i++) begin void'(mq.pop_front()); mq.push_back(w0[i]); end
   endtask

   task automatic test_back_to_back;
      logic [WW-1:0] w0, w1, e0, e1;
      logic [CL-1:0] eh;
      bit tmo;
      int gap;
      for (int p = 0; p < 5; p++) begin
         w0 = 8'($urandom); w1 = 8'($urandom); gap = $urandom_range(0, 4);
         eh = heads_of(w0, w1);
         model_pass(eh, e0, e1);
         do_pass(w0, w1, gap, 1'b0, tmo);
         checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL b2b_timeout pass=%0d got=%b want=0", p, tmo); end
         checks++; if (obs_heads !== eh) begin failures++; $display("FAIL b2b_heads pass=%0d got=%h want=%h", p, obs_heads, eh); end
         checks++; if (en_cnt !== CL || bubbles !== gap) begin failures++; $display("FAIL b2b_shifts pass=%0d got=%0d/%0d want=%0d/%0d", p, en_cnt, bubbles, CL, gap); end
         checks++; if (obs_rb.size() !== 2 || obs_rb[0] !== e0 || obs_rb[1] !== e1) begin failures++; $display("FAIL b2b_readback pass=%0d got=%h,%h want=%h,%h", p, obs_rb[0], obs_rb[1], e0, e1); end
         checks++; if (done_cnt !== 1 || last_rb_cyc !== done_cyc) begin failures++; $display("FAIL b2b_done pass=%0d got=%0d@%0d want=1@%0d", p, done_cnt, last_rb_cyc, done_cyc); end
      end
   endtask

   initial begin
      for (int i = 0; i < CL; i++) mq.push_back(1'b1);
      test_reset;
      test_load;
      test_readback;
      test_underrun;
      test_start_ignored;
      test_abort;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
